// File: rtl/ext_mem_stream_source_if.sv
`default_nettype none
// ============================================================================
//  ext_mem_stream_source_if : memory read port + valid/ready stream bundle
//  Revision: 1.0
// ============================================================================
interface ext_mem_stream_source_if #(
    parameter int DW = 16,
    parameter int AW = 20
);
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_en;
    logic [DW-1:0] mem_qout;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;

    modport master (
        output mem_read_addr,
        output mem_read_en,
        input  mem_qout,
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  mem_read_addr,
        input  mem_read_en,
        output mem_qout,
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/ext_mem_stream_source.sv
`default_nettype none
// ============================================================================
//  ext_mem_stream_source : streams a contiguous memory block out over valid/ready
//  Revision: 1.0
// ============================================================================
module ext_mem_stream_source #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int MEM_WIDTH     = 16,
    parameter int MEM_HEIGHT    = 1 << 20,
    parameter int FIFO_DEPTH    = 2,
    localparam int AW           = $clog2(MEM_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [AW:0]            length,
    output logic                   running,
    output logic                   done,
    ext_mem_stream_source_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] OCC_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   state_q;
    logic [AW-1:0]            addr_q;
    logic [AW:0]              len_q;
    logic [AW:0]              issue_cnt_q;
    logic [AW:0]              sent_cnt_q;
    logic                     inflight_q;
    logic                     done_q;
    logic [IO_DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [CW-1:0]            occ_q;

    logic                     pop_d;
    logic                     push_d;
    logic                     rd_en_d;
    logic [CW:0]              pending_d;

    assign pop_d     = (occ_q != '0) && bus.data_ready;
    assign push_d    = inflight_q;
    assign pending_d = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
    // A read is only issued if its data is guaranteed a FIFO slot when it lands.
    assign rd_en_d   = (state_q == S_RUN) && (issue_cnt_q < len_q) &&
                       (pending_d < (DEPTH_EXT + {{CW{1'b0}}, pop_d}));

    assign bus.mem_read_en   = rd_en_d;
    assign bus.mem_read_addr = addr_q;
    assign bus.data_valid    = (occ_q != '0);
    assign bus.data_out      = fifo_q[rd_ptr_q];
    assign running           = (state_q == S_RUN);
    assign done              = done_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            sent_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        len_q       <= length;
                        issue_cnt_q <= '0;
                        sent_cnt_q  <= '0;
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_en_d) begin
                        issue_cnt_q <= issue_cnt_q + CNT_ONE;
                        addr_q      <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
                    end
                    if (pop_d) begin
                        sent_cnt_q <= sent_cnt_q + CNT_ONE;
                        if ((sent_cnt_q + CNT_ONE) == len_q) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push_d) begin
                fifo_q[wr_ptr_q] <= bus.mem_qout;
                wr_ptr_q         <= (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PTR_ONE;
            end
            if (pop_d) begin
                rd_ptr_q <= (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PTR_ONE;
            end
            case ({push_d, pop_d})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ext_mem_stream_source.sv
`default_nettype none
// ============================================================================
//  tb_ext_mem_stream_source : randomized self-checking bench with word-count model
//  Revision: 1.0
// ============================================================================
module tb_ext_mem_stream_source;
    localparam int DW    = 16;
    localparam int H     = 64;
    localparam int AW    = $clog2(H);
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          running;
    logic          done;

    int n_vec  = 0;
    int n_miss = 0;

    int cfg_mode;
    int cfg_mid_start;
    int cfg_rst_at;
    bit cfg_chain;
    int cfg_next_base;
    int cfg_next_len;

    always #5 clk = ~clk;

    ext_mem_stream_source_if #(.DW(DW), .AW(AW)) bus ();

    ext_mem_stream_source #(
        .IO_DATA_WIDTH(DW),
        .MEM_WIDTH    (DW),
        .MEM_HEIGHT   (H),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .running  (running),
        .done     (done),
        .bus      (bus)
    );

    // Distinct content per address (odd multiplier is a bijection mod 2^16).
    function automatic logic [DW-1:0] memf(input int a);
        int t;
        t = a * 40503 + 17;
        return t[DW-1:0] ^ 16'hC3A5;
    endfunction

    // 1-cycle-latency memory; garbage on idle cycles exposes unintended captures.
    always @(posedge clk) begin
        if (bus.mem_read_en) bus.mem_qout <= memf(int'(bus.mem_read_addr));
        else                 bus.mem_qout <= DW'($urandom);
    end

    task automatic set_cfg(input int mode, input int mid, input int rst_at,
                           input bit chain, input int nb, input int nl);
        cfg_mode      = mode;
        cfg_mid_start = mid;
        cfg_rst_at    = rst_at;
        cfg_chain     = chain;
        cfg_next_base = nb;
        cfg_next_len  = nl;
    endtask

    // Reference: occupancy+inflight = words read - words sent; a word is visible
    // two cycles after its read; done follows the final handshake by one cycle.
    task automatic run_block(input int base, input int len, input bit prestarted);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] exp_addr;
        int  issued, iss_lag, sent, dut_iss, rst_cycle, c;
        bit  last_hs, exp_valid, exp_en, exp_run, exp_done, hs, rdy, finished;
        for (int i = 0; i < len; i++) exp_q.push_back(memf((base + i) % H));
        if (!prestarted) begin
            @(posedge clk); #1;
            start          = 1'b1;
            base_addr      = AW'(base);
            length         = (AW+1)'(len);
            bus.data_ready = 1'b0;
        end
        issued = 0; iss_lag = 0; sent = 0; dut_iss = 0; rst_cycle = -1;
        c = 0; last_hs = 1'b0; finished = 1'b0;
        while (!finished && c < 200) begin
            c++;
            @(posedge clk); #1;
            rst_in = (c == rst_cycle);
            start  = (c == cfg_mid_start);
            if (start) begin
                base_addr = AW'($urandom);
                length    = (AW+1)'($urandom_range(1, 9));
            end
            case (cfg_mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.data_ready = rdy;
            @(negedge clk);
            if (rst_cycle > 0 && c == rst_cycle + 1) begin
                n_vec++;
                if ({running, done, bus.mem_read_en, bus.data_valid} !== 4'b0000) begin
                    n_miss++;
                    $display("FAIL abort_quiet: running,done,read_en,valid=%b required 0000",
                             {running, done, bus.mem_read_en, bus.data_valid});
                end
                finished = 1'b1;
            end else begin
                exp_valid = (iss_lag - sent) > 0;
                hs        = exp_valid && rdy;
                exp_run   = sent < len;
                exp_en    = (issued < len) && ((issued - sent - int'(hs)) < DEPTH);
                exp_done  = last_hs || (len == 0 && c == 1);
                n_vec++;
                if (bus.data_valid !== exp_valid) begin
                    n_miss++;
                    $display("FAIL valid c=%0d: got %b required %b", c, bus.data_valid, exp_valid);
                end
                if (exp_valid && bus.data_valid) begin
                    n_vec++;
                    if (bus.data_out !== exp_q[sent]) begin
                        n_miss++;
                        $display("FAIL data word%0d: got %h required %h", sent, bus.data_out, exp_q[sent]);
                    end
                end
                n_vec++;
                if (bus.mem_read_en !== exp_en) begin
                    n_miss++;
                    $display("FAIL read_en c=%0d: got %b required %b", c, bus.mem_read_en, exp_en);
                end
                if (bus.mem_read_en) begin
                    exp_addr = AW'((base + dut_iss) % H);
                    dut_iss++;
                    n_vec++;
                    if (bus.mem_read_addr !== exp_addr) begin
                        n_miss++;
                        $display("FAIL read_addr c=%0d: got %h required %h", c, bus.mem_read_addr, exp_addr);
                    end
                end
                n_vec++;
                if (running !== exp_run) begin
                    n_miss++;
                    $display("FAIL running c=%0d: got %b required %b", c, running, exp_run);
                end
                n_vec++;
                if (done !== exp_done) begin
                    n_miss++;
                    $display("FAIL done c=%0d: got %b required %b", c, done, exp_done);
                end
                sent = sent + int'(hs);
                n_vec++;
                if ((dut_iss - sent) > DEPTH) begin
                    n_miss++;
                    $display("FAIL overflow c=%0d: outstanding %0d required <= %0d", c, dut_iss - sent, DEPTH);
                end
                iss_lag = issued;
                issued  = issued + int'(exp_en);
                last_hs = hs && (sent == len);
                if (cfg_rst_at > 0 && rst_cycle < 0 && sent == cfg_rst_at) rst_cycle = c + 1;
                if (exp_done) begin
                    finished = 1'b1;
                    if (cfg_chain) begin
                        start     = 1'b1;
                        base_addr = AW'(cfg_next_base);
                        length    = (AW+1)'(cfg_next_len);
                    end
                end
            end
        end
        if (!finished) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: block base=%0d len=%0d incomplete after %0d cycles", base, len, c);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start = 1'b1; base_addr = AW'(5); length = (AW+1)'(3);
        bus.data_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({running, done, bus.mem_read_en, bus.data_valid} !== 4'b0000) begin
            n_miss++;
            $display("FAIL reset_ctrl: running,done,read_en,valid=%b required 0000",
                     {running, done, bus.mem_read_en, bus.data_valid});
        end
        n_vec++;
        if (bus.mem_read_addr !== '0) begin
            n_miss++;
            $display("FAIL reset_addr: got %h required 0", bus.mem_read_addr);
        end
        n_vec++;
        if (bus.data_out !== '0) begin
            n_miss++;
            $display("FAIL reset_data: got %h required 0", bus.data_out);
        end
        @(posedge clk); #1;
        rst_in = 1'b0; start = 1'b0; bus.data_ready = 1'b0;
    endtask

    task automatic test_basic();
        set_cfg(0, 0, 0, 1'b0, 0, 0);
        run_block(16, 4, 1'b0);
    endtask

    task automatic test_backpressure();
        set_cfg(1, 0, 0, 1'b0, 0, 0);
        run_block($urandom_range(0, H - 1), 8, 1'b0);
    endtask

    task automatic test_zero_len();
        set_cfg(2, 0, 0, 1'b0, 0, 0);
        run_block(7, 0, 1'b0);
    endtask

    task automatic test_wrap();
        set_cfg(0, 0, 0, 1'b0, 0, 0);
        run_block(H - 2, 4, 1'b0);
    endtask

    task automatic test_abort();
        set_cfg(2, 3, 2, 1'b0, 0, 0);
        run_block($urandom_range(0, H - 1), 6, 1'b0);
        set_cfg(0, 0, 0, 1'b0, 0, 0);
        run_block(32, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_cfg(0, 0, 0, 1'b1, 40, 3);
        run_block(9, 5, 1'b0);
        set_cfg(2, 0, 0, 1'b0, 0, 0);
        run_block(40, 3, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            set_cfg(2, 0, 0, 1'b0, 0, 0);
            run_block($urandom_range(0, H - 1), $urandom_range(0, 12), 1'b0);
        end
    endtask

    initial begin
        rst_in = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.data_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
